// File: rtl/score_keeper.sv
// score_keeper: per-lane hit/miss capture, serialised one event per cycle
// into combo / multiplier / saturating work score; the displayed score is
// latched from the work score only on frame_start so digits never tear.
// Optional: define STREAK_BONUS_EN to add 100 points whenever a hit makes
// combo land on an exact multiple of 50.

// One pending slot per lane; holds a single event type until serviced.
module sk_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hit,
  input  logic miss,
  input  logic take,
  output logic pend,
  output logic is_hit,
  output logic ovf
);
  logic pulse;
  assign pulse = hit | miss;
  // Pulse lost: slot full and not draining this cycle.
  assign ovf   = pulse & pend & ~take & ~clear;

  // Refill beats release; hit wins a same-cycle hit/miss tie.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend   <= 1'b0;
      is_hit <= 1'b0;
    end else if (clear) begin
      pend   <= 1'b0;
      is_hit <= 1'b0;
    end else if (pulse && (!pend || take)) begin
      pend   <= 1'b1;
      is_hit <= hit;
    end else if (take) begin
      pend   <= 1'b0;
    end
endmodule

module score_keeper #(
  parameter int LANES          = 5,
  parameter int POINTS_PER_HIT = 10,
  parameter int MAX_SCORE      = 99999,
  parameter int COMBO_STEP     = 10,
  parameter int MAX_MULT       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] hit,
  input  logic [LANES-1:0] miss,
  input  logic             frame_start,
  input  logic             clear,
  output logic [16:0]      score,
  output logic [7:0]       combo,
  output logic [2:0]       mult,
  output logic             busy,
  output logic             drop
);
  localparam int SW  = 17;
  localparam int IW  = 18;
  localparam int STW = $clog2(COMBO_STEP + 1);

  localparam logic [IW-1:0]  SMAX      = IW'(MAX_SCORE);
  localparam logic [IW-1:0]  PTS       = IW'(POINTS_PER_HIT);
  localparam logic [2:0]     MMAX      = 3'(MAX_MULT);
  localparam logic [STW-1:0] STEP_LAST = STW'(COMBO_STEP - 1);

  logic [LANES-1:0] pend, is_hit, ovf, take;
  logic             found, sel_hit;

  logic [SW-1:0]    work, work_n;
  logic [STW-1:0]   step, step_n;
  logic [7:0]       combo_n;
  logic [2:0]       mult_n;
  logic [IW-1:0]    add, sum;

  sk_lane u_lane [LANES-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .hit    (hit),
    .miss   (miss),
    .take   (take),
    .pend   (pend),
    .is_hit (is_hit),
    .ovf    (ovf)
  );

  assign busy = |pend;

  // Pick the lowest-index occupied slot for service this cycle.
  always_comb begin
    take    = '0;
    found   = 1'b0;
    sel_hit = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (pend[i] && !found) begin
        found   = 1'b1;
        take[i] = 1'b1;
        sel_hit = is_hit[i];
      end
  end

  // Apply the serviced event; points use the post-update multiplier.
  always_comb begin
    combo_n = combo;
    mult_n  = mult;
    step_n  = step;
    work_n  = work;
    add     = '0;
    sum     = '0;
    if (found) begin
      if (sel_hit) begin
        combo_n = (combo == 8'hFF) ? combo : combo + 8'd1;
        if (step == STEP_LAST) begin
          step_n = '0;
          if (mult < MMAX) mult_n = mult + 3'd1;
        end else begin
          step_n = step + STW'(1);
        end
        add = IW'(mult_n) * PTS;
`ifdef STREAK_BONUS_EN
        if ((combo_n % 8'd50) == 8'd0) add = add + IW'(100);
`endif
        sum    = {1'b0, work} + add;
        work_n = (sum > SMAX) ? SMAX[SW-1:0] : sum[SW-1:0];
      end else begin
        combo_n = '0;
        mult_n  = 3'd1;
        step_n  = '0;
      end
    end
  end

  // Game state; clear overrides everything, score tracks work only at frame_start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      score <= '0;
      work  <= '0;
      combo <= '0;
      mult  <= 3'd1;
      step  <= '0;
      drop  <= 1'b0;
    end else if (clear) begin
      score <= '0;
      work  <= '0;
      combo <= '0;
      mult  <= 3'd1;
      step  <= '0;
      drop  <= 1'b0;
    end else begin
      work  <= work_n;
      combo <= combo_n;
      mult  <= mult_n;
      step  <= step_n;
      if (|ovf)        drop  <= 1'b1;
      if (frame_start) score <= work_n;
    end
endmodule
